// File: rtl/sc_n_adder_tree.sv
// Pipelined stochastic scaled adder: balanced tree of 2:1 mux adders plus a windowed ones-counter.
// Define SC_EXT_SEL_EN to drive the per-level selects from the sel_ext port instead of the LFSR.
module sc_n_adder_tree #(
  parameter int unsigned N      = 8,
  parameter int unsigned WINDOW = 256,
  parameter logic [15:0] SEED   = 16'hACE1,
  localparam int unsigned LEVELS = $clog2(N),
  localparam int unsigned CW     = $clog2(WINDOW + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [N-1:0]      inputs,
`ifdef SC_EXT_SEL_EN
  input  logic [LEVELS-1:0] sel_ext,
`endif
  output logic              sum,
  output logic              sum_valid,
  output logic [CW-1:0]     count,
  output logic              done
);

  localparam int Leaves = 1 << LEVELS;

  logic [LEVELS-1:0]   sel_now;
  logic [LEVELS-1:0]   sel_lvl;
  logic [Leaves-1:0]   leaves;
  logic [Leaves-2:0]   tree_q, tree_d;
  logic [2*Leaves-2:0] nodes;
  logic [LEVELS-1:0]   vld_q;
  logic [CW-1:0]       wcnt_q, acc_q, count_q;
  logic                done_q;

`ifdef SC_EXT_SEL_EN
  assign sel_now = sel_ext;
`else
  logic [15:0] lfsr_q;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting left
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else if (clr) begin
      lfsr_q <= SEED;
    end else if (in_valid) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign sel_now = lfsr_q[LEVELS-1:0];
`endif

  // Level k registers k cycles after its inputs, so its select is delayed k cycles to match.
  for (genvar k = 0; k < LEVELS; k++) begin : g_sel
    if (k == 0) begin : g_now
      assign sel_lvl[0] = sel_now[0];
    end else begin : g_dly
      logic [k-1:0] sh_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sh_q <= '0;
        end else begin
          sh_q[0] <= sel_now[k];
          for (int j = 1; j < k; j++) begin
            sh_q[j] <= sh_q[j-1];
          end
        end
      end
      assign sel_lvl[k] = sh_q[k-1];
    end
  end

  always_comb begin
    leaves         = '0;
    leaves[N-1:0]  = inputs;
  end

  // Flat node array: leaves at the bottom, then each registered level stacked above it.
  assign nodes = {tree_q, leaves};

  always_comb begin
    tree_d = tree_q;
    for (int k = 0; k < LEVELS; k++) begin
      for (int i = 0; i < (Leaves >> (k + 1)); i++) begin
        tree_d[Leaves - (Leaves >> k) + i] =
            sel_lvl[k] ? nodes[2*Leaves - 2*(Leaves >> k) + 2*i + 1]
                       : nodes[2*Leaves - 2*(Leaves >> k) + 2*i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tree_q <= '0;
    end else begin
      tree_q <= tree_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
    end else if (clr) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int j = 1; j < int'(LEVELS); j++) begin
        vld_q[j] <= vld_q[j-1];
      end
    end
  end

  assign sum       = tree_q[Leaves-2];
  assign sum_valid = vld_q[LEVELS-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q  <= '0;
      acc_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clr) begin
        wcnt_q <= '0;
        acc_q  <= '0;
      end else if (sum_valid) begin
        if (wcnt_q == CW'(WINDOW - 1)) begin
          count_q <= acc_q + CW'(sum);
          done_q  <= 1'b1;
          wcnt_q  <= '0;
          acc_q   <= '0;
        end else begin
          wcnt_q <= wcnt_q + CW'(1);
          acc_q  <= acc_q + CW'(sum);
        end
      end
    end
  end

  assign count = count_q;
  assign done  = done_q;

endmodule

// File: tb/tb_sc_n_adder_tree.sv
// Directed bench for sc_n_adder_tree: N=8/W=16, N=5/W=256 against an LFSR reference, N=2/W=1.
module tb_sc_n_adder_tree;

  logic       clk, rst, clr;
  logic       iv8, sum8, sv8, done8;
  logic [7:0] in8;
  logic [4:0] cnt8;
  logic       iv5, sum5, sv5, done5;
  logic [4:0] in5;
  logic [8:0] cnt5;
  logic       iv1, sum1, sv1, done1;
  logic [1:0] in1;
  logic [0:0] cnt1;

  int checks = 0;
  int errors = 0;

  sc_n_adder_tree #(.N(8), .WINDOW(16), .SEED(16'hACE1)) u8 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(iv8), .inputs(in8),
    .sum(sum8), .sum_valid(sv8), .count(cnt8), .done(done8)
  );

  sc_n_adder_tree #(.N(5), .WINDOW(256), .SEED(16'hACE1)) u5 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(iv5), .inputs(in5),
    .sum(sum5), .sum_valid(sv5), .count(cnt5), .done(done5)
  );

  sc_n_adder_tree #(.N(2), .WINDOW(1), .SEED(16'hACE1)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(iv1), .inputs(in1),
    .sum(sum1), .sum_valid(sv1), .count(cnt1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  // Steps until u8 pulses done; n is the step index of the pulse, or -1 if the bound ran out.
  task automatic wait_done8(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (done8 === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // N=5 all-ones tree output for select bits s[2:0] (leaves 5..7 padded with zero).
  function automatic logic f5(input logic [15:0] s);
    return s[2] ? (s[1] ? 1'b0 : ~s[0]) : 1'b1;
  endfunction

  initial begin
    int n, first_sv, first_done, bad, ndone, pushed, ones, w;
    logic [15:0] m;
    logic [8:0] exp_cnt [2];
    logic [8:0] got_cnt [2];
    logic exp_q [$];
    logic iv_hist [64];

    rst = 1'b0; clr = 1'b0;
    iv8 = 1'b0; in8 = '0; iv5 = 1'b0; in5 = '0; iv1 = 1'b0; in1 = '0;
    step();
    step();
    chk("reset_sum_valid", sv8, 0);
    chk("reset_count", cnt8, 0);
    chk("reset_done", done8, 0);
    chk("reset_sum", sum8, 0);
    rst = 1'b1;

    // All ones, continuous valid
    in8 = 8'hFF; iv8 = 1'b1;
    first_sv = -1; first_done = -1; bad = 0;
    for (int s = 1; s <= 19; s++) begin
      step();
      if (sv8 === 1'b1 && first_sv < 0) first_sv = s;
      if (sv8 === 1'b1 && sum8 !== 1'b1) bad++;
      if (done8 === 1'b1 && first_done < 0) first_done = s;
    end
    chk("ones_sv_latency", first_sv, 3);
    chk("ones_done_step", first_done, 19);
    chk("ones_count", cnt8, 16);
    chk("ones_sum_bits", bad, 0);

    // Zeros from here; clr on the completing cycle of the next window (would give 3)
    in8 = 8'h00;
    ndone = 0;
    for (int s = 20; s <= 34; s++) begin
      step();
      if (done8 === 1'b1) ndone++;
    end
    chk("mid_window_no_done", ndone, 0);
    clr = 1'b1;
    step();
    chk("clr_no_done", done8, 0);
    chk("clr_keeps_count", cnt8, 16);
    chk("clr_drops_valid", sv8, 0);
    clr = 1'b0;
    wait_done8(40, n);
    chk("after_clr_done_step", n, 19);
    chk("zeros_count", cnt8, 0);
    wait_done8(40, n);
    chk("zeros_done_period", n, 16);
    chk("zeros_count_2", cnt8, 0);

    // Reset at valid bit 7 of a window
    reset_pulse();
    in8 = 8'hFF;
    wait_done8(40, n);
    chk("rst_pre_done", n, 19);
    chk("rst_pre_count", cnt8, 16);
    for (int s = 0; s < 7; s++) step();
    rst = 1'b0;
    #1;
    chk("rst_async_count", cnt8, 0);
    chk("rst_async_done", done8, 0);
    chk("rst_async_valid", sv8, 0);
    step();
    rst = 1'b1;
    wait_done8(40, n);
    chk("rst_restart_done", n, 19);
    chk("rst_restart_count", cnt8, 16);

    // Alternating in_valid
    reset_pulse();
    in8 = 8'hFF;
    first_done = -1; bad = 0;
    for (int s = 0; s < 40; s++) begin
      iv8 = (s % 2 == 0);
      iv_hist[s] = iv8;
      step();
      if (sv8 !== ((s + 1 >= 3) ? iv_hist[s-2] : 1'b0)) bad++;
      if (done8 === 1'b1 && first_done < 0) first_done = s + 1;
    end
    iv8 = 1'b0;
    chk("toggle_sv_pattern", bad, 0);
    chk("toggle_done_step", first_done, 34);
    chk("toggle_count", cnt8, 16);

    // N=5: bit-exact against the LFSR model, second window with gaps in in_valid
    reset_pulse();
    in5 = 5'b11111;
    m = 16'hACE1; bad = 0; ndone = 0; pushed = 0; ones = 0; w = 0;
    for (int t = 1; t <= 800; t++) begin
      iv5 = (pushed < 256) ? 1'b1 : ((t % 3) != 0 && pushed < 512);
      if (iv5) begin
        exp_q.push_back(f5(m));
        ones += int'(f5(m));
        m = lfsr_adv(m);
        pushed++;
        if (pushed % 256 == 0) begin
          exp_cnt[w] = 9'(ones);
          ones = 0;
          w++;
        end
      end
      step();
      if (sv5 === 1'b1) begin
        if (exp_q.size() == 0) bad++;
        else if (sum5 !== exp_q.pop_front()) bad++;
      end
      if (done5 === 1'b1) begin
        got_cnt[ndone] = cnt5;
        ndone++;
        if (ndone == 2) break;
      end
    end
    iv5 = 1'b0;
    chk("n5_done_count", ndone, 2);
    chk("n5_stream_bits", bad, 0);
    if (ndone == 2) begin
      chk("n5_window0_count", got_cnt[0], exp_cnt[0]);
      chk("n5_window1_count", got_cnt[1], exp_cnt[1]);
      chk("n5_window0_range", (got_cnt[0] >= 136 && got_cnt[0] <= 184), 1);
    end

    // N=2, WINDOW=1
    in1 = 2'b11; iv1 = 1'b1;
    step();
    chk("w1_sum_valid", sv1, 1);
    chk("w1_sum_one", sum1, 1);
    in1 = 2'b00;
    step();
    chk("w1_done_a", done1, 1);
    chk("w1_count_a", cnt1, 1);
    step();
    chk("w1_sum_zero", sum1, 0);
    step();
    chk("w1_done_b", done1, 1);
    chk("w1_count_b", cnt1, 0);
    iv1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
